// File: rtl/sdram_arbit.sv
// ---------------------------------------------------------------------------
// sdram_arbit
//
// Arbiter between the four SDRAM engines (power-up init, auto-refresh,
// write, read). After init completes it grants the bus to one engine at a
// time and steers that engine's command bus onto the SDRAM pins.
//
// Arbitration rules:
//   - Priority is refresh, then write, then read.
//   - Requests are only sampled in IDLE.
//   - A grant lasts until the granted engine raises its *_end.
//   - There is always at least one IDLE cycle between two grants.
//
// Ports
//   sys_clk, sys_rst         clock, asynchronous active-low reset
//   init_*                   init engine: done flag + cmd/ba/addr
//   aref_*                   refresh engine: request, done, cmd/ba/addr
//   wr_*, write_*            write engine: request, done, cmd/ba/addr,
//                            data-drive enable and write data
//   rd_*, read_*             read engine: request, done, cmd/ba/addr
//   aref_en, wr_en, rd_en    grants back to the engines
//   sdram_*                  SDRAM command pins, bank/address, DQ drive
// ---------------------------------------------------------------------------
module sdram_arbit #(
    parameter int DQ_W = 16
) (
    input  logic            sys_clk,
    input  logic            sys_rst,

    input  logic            init_end,
    input  logic [3:0]      init_cmd,
    input  logic [1:0]      init_ba,
    input  logic [12:0]     init_addr,

    input  logic            aref_req,
    input  logic            aref_end,
    input  logic [3:0]      aref_cmd,
    input  logic [1:0]      aref_ba,
    input  logic [12:0]     aref_addr,

    input  logic            wr_req,
    input  logic            wr_end,
    input  logic [3:0]      write_cmd,
    input  logic [1:0]      write_ba,
    input  logic [12:0]     write_addr,
    input  logic            wr_sdram_en,
    input  logic [DQ_W-1:0] wr_sdram_data,

    input  logic            rd_req,
    input  logic            rd_end,
    input  logic [3:0]      read_cmd,
    input  logic [1:0]      read_ba,
    input  logic [12:0]     read_addr,

    output logic            aref_en,
    output logic            wr_en,
    output logic            rd_en,

    output logic            sdram_cke,
    output logic            sdram_cs_n,
    output logic            sdram_ras_n,
    output logic            sdram_cas_n,
    output logic            sdram_we_n,
    output logic [1:0]      sdram_ba,
    output logic [12:0]     sdram_addr,
    output logic [DQ_W-1:0] sdram_dq_out,
    output logic            sdram_dq_oe
);

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [1:0]  BA_IDLE  = 2'b11;
    localparam logic [12:0] ADR_IDLE = 13'h1FFF;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]  cmd_sel;
    logic [1:0]  ba_sel;
    logic [12:0] addr_sel;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Every grant returns to IDLE, which is what guarantees the gap cycle
    // between operations. Requests are only looked at from IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT: begin
                if (init_end) state_nxt = IDLE;
            end
            IDLE: begin
                if (aref_req)     state_nxt = AREF;
                else if (wr_req)  state_nxt = WRITE;
                else if (rd_req)  state_nxt = READ;
            end
            AREF: begin
                if (aref_end) state_nxt = IDLE;
            end
            WRITE: begin
                if (wr_end) state_nxt = IDLE;
            end
            READ: begin
                if (rd_end) state_nxt = IDLE;
            end
            default: state_nxt = INIT;
        endcase
    end

    // Command bus is steered purely by the current state so that an
    // asynchronous reset immediately hands the pins back to the init engine.
    always_comb begin
        cmd_sel  = CMD_NOP;
        ba_sel   = BA_IDLE;
        addr_sel = ADR_IDLE;
        unique case (state)
            INIT: begin
                cmd_sel  = init_cmd;
                ba_sel   = init_ba;
                addr_sel = init_addr;
            end
            AREF: begin
                cmd_sel  = aref_cmd;
                ba_sel   = aref_ba;
                addr_sel = aref_addr;
            end
            WRITE: begin
                cmd_sel  = write_cmd;
                ba_sel   = write_ba;
                addr_sel = write_addr;
            end
            READ: begin
                cmd_sel  = read_cmd;
                ba_sel   = read_ba;
                addr_sel = read_addr;
            end
            default: begin
                cmd_sel  = CMD_NOP;
                ba_sel   = BA_IDLE;
                addr_sel = ADR_IDLE;
            end
        endcase
    end

    // Grants drop in the same cycle the engine signals done, so the engine
    // sees its enable fall together with its own *_end.
    assign aref_en = (state == AREF)  && !aref_end;
    assign wr_en   = (state == WRITE) && !wr_end;
    assign rd_en   = (state == READ)  && !rd_end;

    assign sdram_cke = 1'b1;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_sel;
    assign sdram_ba   = ba_sel;
    assign sdram_addr = addr_sel;

    // Only the write engine may ever drive DQ.
    assign sdram_dq_oe  = (state == WRITE) && wr_sdram_en;
    assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have parameter: DQ_W, 16, SDRAM data width.
REQ-002 SHALL have port: sys_clk  in  1  controller clock; all state changes on the rising edge.
REQ-003 SHALL have port: sys_rst  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports: init_end in 1, init_cmd in 4, init_ba in 2, init_addr in 13: power-up init engine done flag, command, bank and address.
REQ-005 SHALL have ports: aref_req in 1, aref_end in 1, aref_cmd in 4, aref_ba in 2, aref_addr in 13: auto-refresh engine request, done and command bus.
REQ-006 SHALL have ports: wr_req in 1, wr_end in 1, write_cmd in 4, write_ba in 2, write_addr in 13, wr_sdram_en in 1, wr_sdram_data in DQ_W: write engine request, done, command bus, data-drive enable and data.
REQ-007 SHALL have ports: rd_req in 1, rd_end in 1, read_cmd in 4, read_ba in 2, read_addr in 13: read engine request, done and command bus.
REQ-008 SHALL have outputs: aref_en out 1, wr_en out 1, rd_en out 1: grants to the engines.
REQ-009 SHALL have outputs: sdram_cke out 1, sdram_cs_n/sdram_ras_n/sdram_cas_n/sdram_we_n out 1 each, sdram_ba out 2, sdram_addr out 13, sdram_dq_out out DQ_W, sdram_dq_oe out 1.

Function
REQ-010 SHALL implement states INIT, IDLE, AREF, WRITE, READ; reset state INIT.
REQ-011 INIT SHALL move to IDLE on the first cycle init_end=1; init_end ignored thereafter.
REQ-012 IDLE SHALL select, in priority order, aref_req -> AREF, else wr_req -> WRITE, else rd_req -> READ, else stay IDLE.
REQ-013 AREF/WRITE/READ SHALL return to IDLE on the cycle its engine's *_end=1; otherwise hold.
REQ-014 Requests SHALL be sampled only in IDLE; requests raised elsewhere are not latched, and requesters hold them until granted.
REQ-015 Every operation SHALL pass through at least one IDLE cycle before the next grant (no back-to-back grant).
REQ-016 aref_en SHALL be 1 exactly while state=AREF and aref_end=0; wr_en and rd_en follow the same rule for WRITE and READ.
REQ-017 The command mux SHALL be combinational from state: INIT -> init_*; AREF -> aref_*; WRITE -> write_*; READ -> read_*; IDLE -> cmd 4'b0111 (NOP), ba 2'b11, addr 13'h1FFF.
REQ-018 {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} SHALL equal the selected 4-bit cmd, MSB first.
REQ-019 sdram_cke SHALL be constant 1.
REQ-020 sdram_dq_oe SHALL equal wr_sdram_en when state=WRITE, else 0.
REQ-021 sdram_dq_out SHALL equal wr_sdram_data when sdram_dq_oe=1, else 0.
REQ-022 Grant lasts until *_end, with no timeout; a stuck engine holds the bus.
REQ-023 The *_end of a non-granted engine SHALL have no effect.

Reset
REQ-024 Reset SHALL force state INIT asynchronously, including mid-operation. Outputs then follow the init_* bus, with aref_en=wr_en=rd_en=0 and sdram_dq_oe=0.
REQ-025 After reset release, no grant SHALL issue before init_end has been seen.

Verification
REQ-026 Reset, init_cmd=4'b0010, init_end=0 for 10 cycles -> sdram cmd pins 0010, all grants 0. Then init_end=1 -> IDLE next cycle, pins show NOP/2'b11/13'h1FFF.
REQ-027 In IDLE, aref_req=wr_req=rd_req=1 together -> aref_en=1 next cycle. aref_end pulse -> IDLE for one cycle, then wr_en=1. After wr_end: IDLE, then rd_en=1.
REQ-028 WRITE granted, write_cmd=4'b0100, write_ba=2'b01, write_addr=13'h0010, wr_sdram_en=1, wr_sdram_data=16'hA5A5 -> pins mirror these values, sdram_dq_oe=1, sdram_dq_out=16'hA5A5. Same wr_sdram_en in READ -> sdram_dq_oe=0, sdram_dq_out=0.
REQ-029 rd_req raised while AREF active -> no rd_en until aref_end; rd_en=1 one cycle after IDLE is entered.
REQ-030 sys_rst asserted during WRITE with wr_en=1 -> wr_en=0 and sdram_dq_oe=0 immediately (before the next edge); state INIT after release.
REQ-031 rd_end pulsed while in WRITE -> state stays WRITE, wr_en stays 1.
